// File: rtl/m_mem_arb.sv
// m_mem_arb: shares one memory port between a fetch (I) and a data (D) requester, with one
// outstanding transaction and a wait timeout. Define MEM_ARB_FAIRNESS_EN to enable the I-starvation streak limit.
module m_mem_arb #(
   parameter int STREAK_MAX = 4,
   parameter int TMO        = 255
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        w_i_req,
   input  logic [31:0] w_i_addr,
   output logic        w_i_gnt,
   output logic        w_i_rvalid,
   output logic [31:0] w_i_rdata,
   input  logic        w_d_req,
   input  logic        w_d_we,
   input  logic [31:0] w_d_addr,
   input  logic [31:0] w_d_wdata,
   output logic        w_d_gnt,
   output logic        w_d_rvalid,
   output logic [31:0] w_d_rdata,
   output logic        w_m_req,
   output logic        w_m_we,
   output logic [31:0] w_m_addr,
   output logic [31:0] w_m_wdata,
   input  logic        w_m_rdy,
   input  logic        w_m_rvalid,
   input  logic [31:0] w_m_rdata,
   output logic        w_err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e      state_q, state_d;
   logic [9:0]  tmo_q, tmo_d;
   logic        err_q, err_d;
   logic        sel_i, tmo_hit, fair_override;
   logic        m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid;
   logic [31:0] m_addr, m_wdata, i_rdata, d_rdata;

`ifdef MEM_ARB_FAIRNESS_EN
   logic [3:0]  streak_q, streak_d;

   assign fair_override = (streak_q == 4'(STREAK_MAX));

   always_comb begin
      streak_d = streak_q;
      if (i_gnt)
         streak_d = '0;
      else if (d_gnt && w_i_req && !fair_override)
         streak_d = streak_q + 4'd1;
   end
`else
   logic unused_streak_max;
   assign unused_streak_max = |4'(STREAK_MAX);
   assign fair_override     = 1'b0;
`endif

   assign sel_i   = w_i_req && (!w_d_req || fair_override);
   assign tmo_hit = (tmo_q == 10'(TMO - 1));

   // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      m_req    = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      i_rdata  = '0;
      d_rdata  = '0;
      case (state_q)
         IDLE: begin
            m_req = w_i_req || w_d_req;
            if (sel_i) begin
               m_addr = w_i_addr;
               i_gnt  = w_m_rdy;
            end else if (w_d_req) begin
               m_addr  = w_d_addr;
               m_we    = w_d_we;
               m_wdata = w_d_wdata;
               d_gnt   = w_m_rdy;
            end
            if (m_req && w_m_rdy) begin
               state_d = sel_i ? BUSY_I : BUSY_D;
               tmo_d   = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            // A completion in the timeout cycle wins: data is delivered and no error is flagged.
            if (w_m_rvalid || tmo_hit) begin
               state_d = IDLE;
               if (!w_m_rvalid)
                  err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 10'd1;
            end
            if (state_q == BUSY_I) begin
               i_rvalid = w_m_rvalid || tmo_hit;
               i_rdata  = w_m_rvalid ? w_m_rdata : '0;
            end else begin
               d_rvalid = w_m_rvalid || tmo_hit;
               d_rdata  = w_m_rvalid ? w_m_rdata : '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced to zero while reset is asserted; next-state logic stays ungated.
   always_comb begin
      w_m_req    = w_rst_n && m_req;
      w_m_we     = w_rst_n && m_we;
      w_m_addr   = w_rst_n ? m_addr  : '0;
      w_m_wdata  = w_rst_n ? m_wdata : '0;
      w_i_gnt    = w_rst_n && i_gnt;
      w_d_gnt    = w_rst_n && d_gnt;
      w_i_rvalid = w_rst_n && i_rvalid;
      w_d_rvalid = w_rst_n && d_rvalid;
      w_i_rdata  = w_rst_n ? i_rdata : '0;
      w_d_rdata  = w_rst_n ? d_rdata : '0;
      w_err      = err_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q  <= IDLE;
         tmo_q    <= '0;
         err_q    <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
         streak_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
`ifdef MEM_ARB_FAIRNESS_EN
         streak_q <= streak_d;
`endif
      end
   end

endmodule

// File: tb/tb_m_mem_arb.sv
// tb_m_mem_arb: directed self-checking bench for m_mem_arb (TMO=8, STREAK_MAX=4).
module tb_m_mem_arb;

   logic        w_clk = 1'b0;
   logic        w_rst_n;
   logic        w_i_req, w_d_req, w_d_we, w_m_rdy, w_m_rvalid;
   logic [31:0] w_i_addr, w_d_addr, w_d_wdata, w_m_rdata;
   logic        w_i_gnt, w_i_rvalid, w_d_gnt, w_d_rvalid, w_m_req, w_m_we, w_err;
   logic [31:0] w_i_rdata, w_d_rdata, w_m_addr, w_m_wdata;
   logic [134:0] all_out;

   int checks   = 0;
   int failures = 0;

   always #5 w_clk = ~w_clk;

   assign all_out = {w_i_gnt, w_i_rvalid, w_i_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
                     w_m_req, w_m_we, w_m_addr, w_m_wdata, w_err};

   m_mem_arb #(.STREAK_MAX(4), .TMO(8)) dut (
      .w_clk(w_clk), .w_rst_n(w_rst_n),
      .w_i_req(w_i_req), .w_i_addr(w_i_addr), .w_i_gnt(w_i_gnt),
      .w_i_rvalid(w_i_rvalid), .w_i_rdata(w_i_rdata),
      .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
      .w_d_gnt(w_d_gnt), .w_d_rvalid(w_d_rvalid), .w_d_rdata(w_d_rdata),
      .w_m_req(w_m_req), .w_m_we(w_m_we), .w_m_addr(w_m_addr), .w_m_wdata(w_m_wdata),
      .w_m_rdy(w_m_rdy), .w_m_rvalid(w_m_rvalid), .w_m_rdata(w_m_rdata),
      .w_err(w_err)
   );

   task automatic next_cycle();
      @(posedge w_clk);
      #1;
   endtask

   task automatic clear_inputs();
      w_i_req = 0; w_i_addr = '0; w_d_req = 0; w_d_we = 0; w_d_addr = '0; w_d_wdata = '0;
      w_m_rdy = 0; w_m_rvalid = 0; w_m_rdata = '0;
   endtask

   task automatic apply_reset();
      w_rst_n = 0;
      clear_inputs();
      repeat (2) @(posedge w_clk);
      #1;
      w_rst_n = 1;
   endtask

   task automatic test_reset();
      w_rst_n = 0;
      w_i_req = 1; w_i_addr = 32'h40; w_d_req = 1; w_d_we = 1; w_d_addr = 32'h100;
      w_d_wdata = 32'hDEADBEEF; w_m_rdy = 1; w_m_rvalid = 1; w_m_rdata = 32'h1234;
      @(negedge w_clk);
      checks++;
      if (all_out !== '0) begin
         failures++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      apply_reset();
      @(negedge w_clk);
      checks++;
      if ({w_err, w_m_req, w_i_gnt, w_d_gnt} !== 4'b0000) begin
         failures++; $display("FAIL reset_release_idle: got %b want 0000", {w_err, w_m_req, w_i_gnt, w_d_gnt});
      end
   endtask

   task automatic test_fetch();
      apply_reset();
      w_i_req = 1; w_i_addr = 32'h40; w_m_rdy = 1;
      @(negedge w_clk);
      checks++;
      if ({w_i_gnt, w_m_req, w_m_we, w_m_addr} !== {1'b1, 1'b1, 1'b0, 32'h40}) begin
         failures++; $display("FAIL fetch_c0: got gnt=%b req=%b we=%b addr=%h want 1 1 0 00000040",
                              w_i_gnt, w_m_req, w_m_we, w_m_addr);
      end
      next_cycle();
      @(negedge w_clk);
      checks++;
      if ({w_i_gnt, w_m_req, w_i_rvalid} !== 3'b000) begin
         failures++; $display("FAIL fetch_c1_busy: got %b want 000", {w_i_gnt, w_m_req, w_i_rvalid});
      end
      next_cycle();
      w_m_rvalid = 1; w_m_rdata = 32'h13;
      @(negedge w_clk);
      checks++;
      if ({w_i_rvalid, w_i_rdata, w_d_rvalid, w_d_rdata} !== {1'b1, 32'h13, 1'b0, 32'h0}) begin
         failures++; $display("FAIL fetch_c2_data: got iv=%b id=%h dv=%b dd=%h want 1 00000013 0 0",
                              w_i_rvalid, w_i_rdata, w_d_rvalid, w_d_rdata);
      end
      next_cycle();
      w_m_rvalid = 0;
      @(negedge w_clk);
      checks++;
      if (w_i_gnt !== 1'b1) begin
         failures++; $display("FAIL fetch_c3_regrant: got %b want 1", w_i_gnt);
      end
   endtask

   task automatic test_priority();
      apply_reset();
      w_i_req = 1; w_i_addr = 32'h40; w_m_rdy = 1;
      w_d_req = 1; w_d_we = 1; w_d_addr = 32'h100; w_d_wdata = 32'hDEADBEEF;
      @(negedge w_clk);
      checks++;
      if ({w_d_gnt, w_i_gnt, w_m_we, w_m_addr, w_m_wdata} !== {3'b101, 32'h100, 32'hDEADBEEF}) begin
         failures++; $display("FAIL prio_store: got dg=%b ig=%b we=%b addr=%h wd=%h want 1 0 1 00000100 deadbeef",
                              w_d_gnt, w_i_gnt, w_m_we, w_m_addr, w_m_wdata);
      end
      next_cycle();
      w_d_req = 0; w_d_we = 0; w_m_rvalid = 1; w_m_rdata = 32'h0;
      @(negedge w_clk);
      checks++;
      if ({w_d_rvalid, w_i_gnt, w_i_rvalid} !== 3'b100) begin
         failures++; $display("FAIL prio_store_done: got %b want 100", {w_d_rvalid, w_i_gnt, w_i_rvalid});
      end
      next_cycle();
      w_m_rvalid = 0;
      @(negedge w_clk);
      checks++;
      if ({w_i_gnt, w_m_we, w_m_addr} !== {2'b10, 32'h40}) begin
         failures++; $display("FAIL prio_i_after_d: got ig=%b we=%b addr=%h want 1 0 00000040",
                              w_i_gnt, w_m_we, w_m_addr);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_seq [6];
`ifdef MEM_ARB_FAIRNESS_EN
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
      apply_reset();
      w_i_req = 1; w_i_addr = 32'h80; w_d_req = 1; w_d_addr = 32'h200; w_m_rdy = 1;
      for (int g = 0; g < 6; g++) begin
         @(negedge w_clk);
         checks++;
         if ({w_i_gnt, w_d_gnt} !== exp_seq[g]) begin
            failures++; $display("FAIL fair_grant%0d: got {i,d}=%b want %b", g, {w_i_gnt, w_d_gnt}, exp_seq[g]);
         end
         next_cycle();
         w_m_rvalid = 1;
         next_cycle();
         w_m_rvalid = 0;
      end
   endtask

   task automatic test_rdy_stall();
      apply_reset();
      w_d_req = 1; w_d_addr = 32'h300; w_m_rdy = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge w_clk);
         checks++;
         if ({w_d_gnt, w_i_gnt, w_m_req} !== 3'b001) begin
            failures++; $display("FAIL stall_c%0d: got gnt/req=%b want 001", c, {w_d_gnt, w_i_gnt, w_m_req});
         end
         next_cycle();
      end
      w_m_rdy = 1;
      @(negedge w_clk);
      checks++;
      if ({w_d_gnt, w_m_addr} !== {1'b1, 32'h300}) begin
         failures++; $display("FAIL stall_release: got gnt=%b addr=%h want 1 00000300", w_d_gnt, w_m_addr);
      end
   endtask

   task automatic run_timeout(input bit late_data);
      apply_reset();
      w_d_req = 1; w_d_addr = 32'h400; w_m_rdy = 1;
      @(negedge w_clk);
      checks++;
      if (w_d_gnt !== 1'b1) begin
         failures++; $display("FAIL tmo_grant: got %b want 1", w_d_gnt);
      end
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         w_d_req = 0;
         if (k == 8 && late_data) begin
            w_m_rvalid = 1; w_m_rdata = 32'hA5A5A5A5;
         end
         @(negedge w_clk);
         if (k < 8) begin
            checks++;
            if (w_d_rvalid !== 1'b0) begin
               failures++; $display("FAIL tmo_wait%0d: got rvalid=%b want 0", k, w_d_rvalid);
            end
         end else begin
            checks++;
            if ({w_d_rvalid, w_d_rdata, w_err} !== {1'b1, (late_data ? 32'hA5A5A5A5 : 32'h0), 1'b0}) begin
               failures++; $display("FAIL tmo_fire_%0d: got v=%b d=%h err=%b want 1 %h 0", late_data,
                                    w_d_rvalid, w_d_rdata, w_err, (late_data ? 32'hA5A5A5A5 : 32'h0));
            end
         end
      end
      next_cycle();
      w_m_rvalid = 1; w_m_rdata = 32'h77;
      @(negedge w_clk);
      checks++;
      if ({w_err, w_d_rvalid, w_d_rdata} !== {!late_data, 1'b0, 32'h0}) begin
         failures++; $display("FAIL tmo_after_%0d: got err=%b v=%b d=%h want %b 0 0", late_data,
                              w_err, w_d_rvalid, w_d_rdata, !late_data);
      end
   endtask

   task automatic test_timeout();
      run_timeout(1'b0);
      next_cycle();
      w_rst_n = 0;
      @(negedge w_clk);
      checks++;
      if (w_err !== 1'b0) begin
         failures++; $display("FAIL tmo_err_reset: got %b want 0", w_err);
      end
      run_timeout(1'b1);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      w_d_req = 1; w_d_addr = 32'h500; w_m_rdy = 1;
      next_cycle();
      w_d_req = 0;
      #1;
      w_rst_n = 0;
      w_i_req = 1; w_d_req = 1; w_d_we = 1; w_m_rvalid = 1; w_m_rdata = 32'h55;
      @(negedge w_clk);
      checks++;
      if (all_out !== '0) begin
         failures++; $display("FAIL midrst_outputs: got %h want 0", all_out);
      end
      next_cycle();
      w_rst_n = 1;
      w_i_req = 0; w_d_req = 0; w_d_we = 0;
      @(negedge w_clk);
      checks++;
      if ({w_d_rvalid, w_i_rvalid, w_m_req, w_err} !== 4'b0000) begin
         failures++; $display("FAIL midrst_late_rvalid: got %b want 0000", {w_d_rvalid, w_i_rvalid, w_m_req, w_err});
      end
      next_cycle();
      w_m_rvalid = 0; w_d_req = 1;
      @(negedge w_clk);
      checks++;
      if (w_d_gnt !== 1'b1) begin
         failures++; $display("FAIL midrst_idle_grant: got %b want 1", w_d_gnt);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fetch();
      test_priority();
      test_fairness();
      test_rdy_stall();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
